// File: rtl/sprite_compositor_if.sv
// Scan, sprite and composited-pixel signals between the video timing/sprite logic and the compositor.
interface sprite_compositor_if;
  logic        pixel_en;
  logic        frame_start;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        video_active;
  logic [9:0]  p1_x;
  logic [9:0]  p1_y;
  logic [9:0]  p2_x;
  logic [9:0]  p2_y;
  logic [7:0]  p1_color;
  logic [7:0]  p2_color;
  logic [7:0]  rgb_out;
  logic        rgb_valid;
  logic        collision;
  logic [15:0] overlap_count;

  modport master (
    output pixel_en, frame_start, hcount, vcount, video_active,
           p1_x, p1_y, p2_x, p2_y, p1_color, p2_color,
    input  rgb_out, rgb_valid, collision, overlap_count
  );

  modport slave (
    input  pixel_en, frame_start, hcount, vcount, video_active,
           p1_x, p1_y, p2_x, p2_y, p1_color, p2_color,
    output rgb_out, rgb_valid, collision, overlap_count
  );
endinterface

// File: rtl/sprite_compositor.sv
// Two-sprite RGB332 compositor, 2 pixel_en cycles of latency, P1 over P2 over BG_COLOR.
// Overlap accumulator and collision reporting exist only when SPRITE_COLLISION_EN is defined.
module sprite_compositor #(
  parameter int          SPRITE_WIDTH  = 64,
  parameter int          SPRITE_HEIGHT = 64,
  parameter logic [7:0]  BG_COLOR      = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  sprite_compositor_if.slave   bus
);

  logic [9:0] p1x_q, p1y_q, p2x_q, p2y_q;
  logic [7:0] c1_q, c2_q;
  logic       hit1_q, hit1_d, hit2_q, hit2_d, act_q;
  logic [7:0] rgb_q, rgb_d;
  logic       vld_q;

  // 11-bit compares so a sprite near the right/bottom edge cannot wrap to column/row 0
  function automatic logic in_box(input logic [9:0] h, input logic [9:0] v,
                                  input logic [9:0] x, input logic [9:0] y,
                                  input logic [7:0] c);
    logic [10:0] hh, vv, xx, yy;
    hh = {1'b0, h};
    vv = {1'b0, v};
    xx = {1'b0, x};
    yy = {1'b0, y};
    return (hh >= xx) && (hh < xx + 11'(SPRITE_WIDTH)) &&
           (vv >= yy) && (vv < yy + 11'(SPRITE_HEIGHT)) && (c != 8'h00);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1x_q <= '0; p1y_q <= '0; p2x_q <= '0; p2y_q <= '0;
      c1_q  <= '0; c2_q  <= '0;
    end else if (bus.frame_start) begin
      p1x_q <= bus.p1_x; p1y_q <= bus.p1_y;
      p2x_q <= bus.p2_x; p2y_q <= bus.p2_y;
      c1_q  <= bus.p1_color; c2_q <= bus.p2_color;
    end
  end

  always_comb begin
    hit1_d = in_box(bus.hcount, bus.vcount, p1x_q, p1y_q, c1_q);
    hit2_d = in_box(bus.hcount, bus.vcount, p2x_q, p2y_q, c2_q);
    rgb_d  = BG_COLOR;
    if (!act_q)      rgb_d = 8'h00;
    else if (hit1_q) rgb_d = c1_q;
    else if (hit2_q) rgb_d = c2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit1_q <= 1'b0; hit2_q <= 1'b0; act_q <= 1'b0;
      rgb_q  <= '0;   vld_q  <= 1'b0;
    end else if (bus.pixel_en) begin
      hit1_q <= hit1_d;
      hit2_q <= hit2_d;
      act_q  <= bus.video_active;
      rgb_q  <= rgb_d;
      vld_q  <= act_q;
    end
  end

  assign bus.rgb_out   = rgb_q;
  assign bus.rgb_valid = vld_q;

`ifdef SPRITE_COLLISION_EN
  logic [15:0] acc_q, acc_d, ovl_q;
  logic        col_q, inc;

  // A stage-1 pixel is counted on the pixel_en edge that moves it into stage 2
  always_comb begin
    inc   = bus.pixel_en && hit1_q && hit2_q && act_q;
    acc_d = acc_q;
    if (bus.frame_start)               acc_d = {15'd0, inc};
    else if (inc && acc_q != 16'hFFFF) acc_d = acc_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0; ovl_q <= '0; col_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (bus.frame_start) begin
        ovl_q <= acc_q;
        col_q <= (acc_q != 16'd0);
      end
    end
  end

  assign bus.collision     = col_q;
  assign bus.overlap_count = ovl_q;
`else
  assign bus.collision     = 1'b0;
  assign bus.overlap_count = 16'd0;
`endif

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter SPRITE_WIDTH, default 64, horizontal sprite size in pixels.
REQ-002 Parameter SPRITE_HEIGHT, default 64, vertical sprite size in pixels.
REQ-003 Parameter BG_COLOR, default 8'h00, 8-bit RGB332 color shown where no sprite covers the pixel.
REQ-004 clk  input  1  system clock, single clock domain.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 pixel_en  input  1  pixel-rate enable; the pipeline advances only on cycles with pixel_en=1.
REQ-007 frame_start  input  1  single-cycle pulse at the start of each frame (vertical blank).
REQ-008 hcount  input  10  current scan column.
REQ-009 vcount  input  10  current scan row.
REQ-010 video_active  input  1  scan position is inside the visible area.
REQ-011 p1_x, p1_y, p2_x, p2_y  input  10 each  sprite top-left positions driven by the two sprite renderers.
REQ-012 p1_color, p2_color  input  8 each  sprite RGB332 colors; 8'h00 means the sprite is transparent.
REQ-013 rgb_out  output  8  composited pixel color.
REQ-014 rgb_valid  output  1  rgb_out corresponds to a visible pixel.
REQ-015 collision  output  1  the sprites overlapped on at least one visible pixel in the previous frame.
REQ-016 overlap_count  output  16  number of overlapping visible pixels in the previous frame, saturating.

Function
REQ-017 On any cycle with frame_start=1, all six position and color inputs SHALL be captured into shadow registers; all compositing SHALL use the shadow copies only.
REQ-018 Stage 1, on pixel_en, SHALL register hit1 = (hcount >= p1_x) && (hcount < p1_x+SPRITE_WIDTH) && (vcount >= p1_y) && (vcount < p1_y+SPRITE_HEIGHT) && (p1_color != 0), with hit2 computed likewise; all sums SHALL be 11-bit so that no wrap-around occurs at the right or bottom edge.
REQ-019 Stage 1 SHALL also register video_active.
REQ-020 Stage 2, on pixel_en, SHALL register rgb_out as follows:
- stage-1 active=0: 8'h00;
- hit1=1: p1_color (P1 has priority);
- hit2=1 only: p2_color;
- otherwise: BG_COLOR.
REQ-021 Stage 2 SHALL register rgb_valid from the stage-1 active flag, giving a total latency of exactly 2 pixel_en cycles from input to output.
REQ-022 When pixel_en=0, every pipeline register and the frame accumulator SHALL hold its value.
REQ-023 A frame accumulator SHALL increment once per stage-1 pixel where hit1, hit2 and active are all 1, saturating at 16'hFFFF.
REQ-024 On frame_start, overlap_count SHALL load the accumulator value and collision SHALL load (accumulator != 0); the accumulator SHALL restart from the current cycle's contribution (0 or 1).
REQ-025 When frame_start and an overlapping stage-1 pixel occur in the same cycle, that pixel SHALL count toward the new frame.
REQ-026 Shadow registers, collision and overlap_count SHALL remain constant between frame_start pulses.

Reset
REQ-027 While rst=1, all outputs SHALL be 0, shadow positions and colors SHALL be 0 (both sprites transparent), all pipeline flags SHALL be 0, and the accumulator SHALL be 0.
REQ-028 When rst asserts mid-frame, it SHALL discard the partial accumulation; the first frame_start after reset SHALL report collision=0 and overlap_count=0 unless overlaps occurred after reset.

Configuration
REQ-029 When the macro SPRITE_COLLISION_EN is defined, REQ-023 to REQ-025 SHALL be implemented as specified.
REQ-030 When SPRITE_COLLISION_EN is undefined, the accumulator SHALL be omitted and collision and overlap_count SHALL be tied to 0; the pixel path SHALL be unchanged.

Verification
REQ-031 Test 1: p1=(100,100, 8'h03), p2 transparent, frame_start, then scan (100,100) active -> rgb_out=8'h03 and rgb_valid=1 exactly 2 pixel_en cycles later; (99,100) -> BG_COLOR; (164,100) -> BG_COLOR.
REQ-032 Test 2: p1=(100,100, 8'hE0), p2=(140,100, 8'hFC), full frame scan, then frame_start -> rgb_out=8'hE0 at (150,120); collision=1; overlap_count=24*64=1536.
REQ-033 Test 3: p2 at x=600 with SPRITE_WIDTH 64 -> pixels 600..639 show p2_color and no wrap-around hit at columns 0..23.
REQ-034 Test 4: change the p1_x input mid-frame -> output unchanged until the next frame_start, then the new position takes effect.
REQ-035 Test 5: hold pixel_en=0 for 5 cycles mid-line -> rgb_out is frozen; on resume, pixel order and latency are intact.
REQ-036 Test 6: assert rst mid-frame during overlap -> all outputs 0 immediately; with SPRITE_COLLISION_EN undefined, collision and overlap_count stay 0 across an overlapping frame.
